tpm_tis_data_provider: RTL

- TPM TIS register/FIFO back-end on the lpc_periph data-provider interface.
- Decodes locality-0 TIS registers and answers read/write handshakes.
- Buffers command bytes from host to firmware and response bytes from firmware to host, and runs the TIS state machine.
- Drives lpc_periph irq_num/interrupt. Top-level glue turns lpc_data_i/o/oe into the shared lpc_data_io inout.

---
 rtl/tpm_tis_data_provider.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tpm_tis_data_provider.sv
// TPM TIS locality-0 register/FIFO back-end for the lpc_periph data-provider port.
// Host side is a level-request / one-cycle-pulse handshake; firmware side is a
// pair of byte FIFOs plus go/done strobes around the TIS state machine.
module tpm_tis_data_provider #(
    parameter int          FIFO_DEPTH = 64,
    parameter logic [31:0] DID_VID    = 32'h0001_1050,
    parameter logic [3:0]  IRQ_NUM    = 4'd10,
    parameter bit          INT_EN     = 1'b1
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [15:0] lpc_addr_i,
    input  logic [7:0]  lpc_data_i,
    output logic [7:0]  lpc_data_o,
    output logic        lpc_data_oe,
    input  logic        lpc_data_wr,
    output logic        lpc_wr_done,
    input  logic        lpc_data_req,
    output logic        lpc_data_rd,
    output logic [3:0]  irq_num,
    output logic        interrupt,
    input  logic        fw_cmd_rd_en,
    output logic [7:0]  fw_cmd_data,
    output logic        fw_cmd_empty,
    output logic        fw_go,
    input  logic        fw_rsp_wr_en,
    input  logic [7:0]  fw_rsp_data,
    output logic        fw_rsp_full,
    input  logic        fw_rsp_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_READY, ST_RECEPTION, ST_EXECUTION, ST_COMPLETION
    } state_t;

    state_t state, state_nxt;

    logic        req_q, wr_q, active_loc;
    logic        rd_start, wr_start;
    logic [11:0] off;
    logic        in_range, sel_access, sel_sts, sel_burst_lo, sel_burst_hi, sel_data, sel_did;

    logic [7:0]  cmd_mem [FIFO_DEPTH];
    logic [7:0]  rsp_mem [FIFO_DEPTH];
    logic [AW:0] cmd_wptr, cmd_rptr, rsp_wptr, rsp_rptr, cmd_fill, rsp_fill;
    logic        cmd_full, rsp_empty;
    logic        cmd_push, cmd_pop, rsp_push, rsp_pop, flush;

    logic [11:0] rx_cnt, cmd_len;
    logic [31:0] len_raw;
    logic        expect_raw, expect_bit, data_avail, go_wr;
    logic [15:0] burst;
    logic [7:0]  rd_val;

    assign rd_start = lpc_data_req & ~req_q;
    assign wr_start = lpc_data_wr & ~wr_q;

    // Address decode; everything but ACCESS needs the locality to be active.
    assign in_range     = (lpc_addr_i[15:12] == 4'h0);
    assign off          = lpc_addr_i[11:0];
    assign sel_access   = in_range & (off == 12'h000);
    assign sel_sts      = in_range & active_loc & (off == 12'h018);
    assign sel_burst_lo = in_range & active_loc & (off == 12'h019);
    assign sel_burst_hi = in_range & active_loc & (off == 12'h01A);
    assign sel_data     = in_range & active_loc & (off == 12'h024);
    assign sel_did      = in_range & active_loc & (off[11:2] == 10'h3C0);

    // Header bytes 2..5 carry the big-endian command length; clamp to 12 bits.
    assign cmd_len    = (|len_raw[31:12]) ? 12'hFFF : len_raw[11:0];
    assign expect_raw = (rx_cnt < 12'd6) || (rx_cnt < cmd_len);
    assign expect_bit = (state == ST_RECEPTION) && expect_raw;

    // Pointers carry one extra wrap bit: equal means empty, MSB-only diff means full.
    assign cmd_fill     = cmd_wptr - cmd_rptr;
    assign rsp_fill     = rsp_wptr - rsp_rptr;
    assign fw_cmd_empty = (cmd_wptr == cmd_rptr);
    assign cmd_full     = (cmd_wptr[AW] != cmd_rptr[AW]) && (cmd_wptr[AW-1:0] == cmd_rptr[AW-1:0]);
    assign rsp_empty    = (rsp_wptr == rsp_rptr);
    assign fw_rsp_full  = (rsp_wptr[AW] != rsp_rptr[AW]) && (rsp_wptr[AW-1:0] == rsp_rptr[AW-1:0]);
    assign fw_cmd_data  = fw_cmd_empty ? 8'h00 : cmd_mem[cmd_rptr[AW-1:0]];

    assign data_avail = (state == ST_COMPLETION) && !rsp_empty;
    assign interrupt  = INT_EN && active_loc && data_avail;
    assign irq_num    = IRQ_NUM;

    // FIFO traffic and host strobes that touch state
    assign flush    = wr_start & sel_sts & lpc_data_i[6];
    assign go_wr    = wr_start & sel_sts & ~lpc_data_i[6] & lpc_data_i[5]
                    & (state == ST_RECEPTION) & ~expect_raw;
    assign cmd_push = wr_start & sel_data & ((state == ST_READY) || (state == ST_RECEPTION))
                    & ~cmd_full & expect_raw;
    assign cmd_pop  = fw_cmd_rd_en & ~fw_cmd_empty;
    assign rsp_push = fw_rsp_wr_en & ~fw_rsp_full;
    assign rsp_pop  = rd_start & sel_data & (state == ST_COMPLETION) & ~rsp_empty;

    // Burst count: free command space while receiving, pending response bytes when complete.
    always_comb begin
        burst = 16'h0000;
        if ((state == ST_READY) || (state == ST_RECEPTION))
            burst = 16'(FIFO_DEPTH) - 16'(cmd_fill);
        else if (state == ST_COMPLETION)
            burst = 16'(rsp_fill);
    end

    // Read data mux; unmapped or locality-blocked addresses float high.
    always_comb begin
        rd_val = 8'hFF;
        if (sel_access)
            rd_val = {1'b1, 1'b0, active_loc, 5'b0};
        else if (sel_sts)
            rd_val = {1'b1, state == ST_READY, 1'b0, data_avail, expect_bit, 3'b0};
        else if (sel_burst_lo)
            rd_val = burst[7:0];
        else if (sel_burst_hi)
            rd_val = burst[15:8];
        else if (sel_data)
            rd_val = rsp_pop ? rsp_mem[rsp_rptr[AW-1:0]] : 8'hFF;
        else if (sel_did)
            rd_val = DID_VID[8*off[1:0] +: 8];
    end

    // Host handshake: edge-detect requests, one-cycle rd/wr_done pulses, oe held while req high.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            lpc_data_o  <= 8'h00;
            lpc_data_oe <= 1'b0;
            lpc_data_rd <= 1'b0;
            lpc_wr_done <= 1'b0;
            fw_go       <= 1'b0;
        end else begin
            req_q       <= lpc_data_req;
            wr_q        <= lpc_data_wr;
            lpc_data_rd <= rd_start;
            lpc_wr_done <= wr_start;
            fw_go       <= go_wr;
            if (rd_start) begin
                lpc_data_o  <= rd_val;
                lpc_data_oe <= 1'b1;
            end else if (!lpc_data_req) begin
                lpc_data_oe <= 1'b0;
            end
        end
    end

    // Locality claim/relinquish; relinquish wins if both bits are set.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i)
            active_loc <= 1'b0;
        else if (wr_start && sel_access) begin
            if (lpc_data_i[5])
                active_loc <= 1'b0;
            else if (lpc_data_i[1])
                active_loc <= 1'b1;
        end
    end

    // FIFO pointers and command length tracking; commandReady flushes everything.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            rsp_wptr <= '0;
            rsp_rptr <= '0;
            rx_cnt   <= '0;
            len_raw  <= '0;
        end else if (flush) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            rsp_wptr <= '0;
            rsp_rptr <= '0;
            rx_cnt   <= '0;
            len_raw  <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wptr <= cmd_wptr + 1'b1;
                rx_cnt   <= rx_cnt + 12'd1;
                if ((rx_cnt >= 12'd2) && (rx_cnt <= 12'd5))
                    len_raw <= {len_raw[23:0], lpc_data_i};
            end
            if (cmd_pop)  cmd_rptr <= cmd_rptr + 1'b1;
            if (rsp_push) rsp_wptr <= rsp_wptr + 1'b1;
            if (rsp_pop)  rsp_rptr <= rsp_rptr + 1'b1;
        end
    end

    // FIFO storage, not reset; reads are guarded by the empty flags.
    always_ff @(posedge clk_i) begin
        if (cmd_push) cmd_mem[cmd_wptr[AW-1:0]] <= lpc_data_i;
        if (rsp_push) rsp_mem[rsp_wptr[AW-1:0]] <= fw_rsp_data;
    end

    // TIS state register
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // TIS next-state: commandReady overrides every other event.
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = ST_READY;
        else begin
            case (state)
                ST_READY:      if (cmd_push)    state_nxt = ST_RECEPTION;
                ST_RECEPTION:  if (go_wr)       state_nxt = ST_EXECUTION;
                ST_EXECUTION:  if (fw_rsp_done) state_nxt = ST_COMPLETION;
                default:       state_nxt = state;
            endcase
        end
    end
endmodule
